// File: rtl/mac_sequencer.sv
// Tap sequencer for a multiply-accumulate datapath: steps a tap select through
// NTAPS positions per frame and pulses latch/clear/done on the final tap.
module mac_sequencer #(
  parameter int NTAPS = 4,
  parameter int SELW  = $clog2(NTAPS),
  parameter int FCW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            cont,
  input  logic            stall,
  output logic [SELW-1:0] muxControl,
  output logic            enData,
  output logic            clearAccum,
  output logic            busy,
  output logic            done,
  output logic [FCW-1:0]  frames
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [SELW-1:0] LAST_IDX = SELW'(NTAPS - 1);

  logic [0:0]      state;
  logic [SELW-1:0] idx;
  logic [FCW-1:0]  frame_cnt;
  logic            in_run;
  logic            last_tap;
  logic            go;

  always_comb begin
    in_run = (state == RUN);
    go     = start | cont;
    // Gated by reset so an aborted frame never emits its end-of-frame pulses.
    last_tap = in_run && !stall && (idx == LAST_IDX) && !reset;
  end

  always_comb begin
    muxControl = in_run ? idx : '0;
    enData     = last_tap;
    clearAccum = last_tap;
    done       = last_tap;
    busy       = in_run;
    frames     = frame_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      frame_cnt <= '0;
    end else if (state == IDLE) begin
      if (go) begin
        state <= RUN;
        idx   <= '0;
      end
    end else if (!stall) begin
      if (idx == LAST_IDX) begin
        // Wrap explicitly so non-power-of-two depths never reach 2^SELW.
        frame_cnt <= frame_cnt + FCW'(1);
        idx       <= '0;
        if (!go) state <= IDLE;
      end else begin
        idx <= idx + SELW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: three instances cover NTAPS=4, NTAPS=5
// and a 2-bit frame counter.
module tb_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // Instance A: NTAPS=4, FCW=8
  logic       rst_a = 1'b1, start_a = 1'b0, cont_a = 1'b0, stall_a = 1'b0;
  logic [1:0] mux_a;
  logic       en_a, clr_a, busy_a, done_a;
  logic [7:0] frames_a;

  // Instance B: NTAPS=5, FCW=8
  logic       rst_b = 1'b1, start_b = 1'b0, cont_b = 1'b0, stall_b = 1'b0;
  logic [2:0] mux_b;
  logic       en_b, clr_b, busy_b, done_b;
  logic [7:0] frames_b;

  // Instance C: NTAPS=4, FCW=2
  logic       rst_c = 1'b1, start_c = 1'b0, cont_c = 1'b0, stall_c = 1'b0;
  logic [1:0] mux_c;
  logic       en_c, clr_c, busy_c, done_c;
  logic [1:0] frames_c;

  mac_sequencer #(.NTAPS(4), .FCW(8)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .cont(cont_a), .stall(stall_a),
    .muxControl(mux_a), .enData(en_a), .clearAccum(clr_a), .busy(busy_a),
    .done(done_a), .frames(frames_a)
  );

  mac_sequencer #(.NTAPS(5), .FCW(8)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .cont(cont_b), .stall(stall_b),
    .muxControl(mux_b), .enData(en_b), .clearAccum(clr_b), .busy(busy_b),
    .done(done_b), .frames(frames_b)
  );

  mac_sequencer #(.NTAPS(4), .FCW(2)) dut_c (
    .clk(clk), .reset(rst_c), .start(start_c), .cont(cont_c), .stall(stall_c),
    .muxControl(mux_c), .enData(en_c), .clearAccum(clr_c), .busy(busy_c),
    .done(done_c), .frames(frames_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Inputs for the cycle are already driven; settle, check, advance one edge.
  task automatic cycle_a(input string tag, input int mux, input bit pulse, input bit bsy);
    #1;
    chk({tag, " mux"},   mux_a,  mux);
    chk({tag, " en"},    en_a,   pulse);
    chk({tag, " clr"},   clr_a,  pulse);
    chk({tag, " done"},  done_a, pulse);
    chk({tag, " busy"},  busy_a, bsy);
    nxt();
  endtask

  task automatic cycle_b(input string tag, input int mux, input bit pulse, input bit bsy);
    #1;
    chk({tag, " mux"},   mux_b,  mux);
    chk({tag, " range"}, (mux_b <= 3'd4), 1);
    chk({tag, " done"},  done_b, pulse);
    chk({tag, " en"},    en_b,   pulse);
    chk({tag, " busy"},  busy_b, bsy);
    nxt();
  endtask

  task automatic cycle_c(input string tag, input int mux, input bit pulse, input bit bsy);
    #1;
    chk({tag, " mux"},   mux_c,  mux);
    chk({tag, " done"},  done_c, pulse);
    chk({tag, " clr"},   clr_c,  pulse);
    chk({tag, " busy"},  busy_c, bsy);
    nxt();
  endtask

  initial begin
    nxt();
    nxt();
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;

    // Reset state
    chk("rst frames_a", frames_a, 0);
    chk("rst frames_b", frames_b, 0);
    chk("rst frames_c", frames_c, 0);
    cycle_a("rst", 0, 0, 0);

    // Single frame; start pulse at idx=1 must be ignored
    start_a = 1'b1;
    cycle_a("t1 idle", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      start_a = (i == 1);
      cycle_a($sformatf("t1 c%0d", i), i, (i == 3), 1);
    end
    start_a = 1'b0;
    chk("t1 frames", frames_a, 1);
    cycle_a("t1 after", 0, 0, 0);
    cycle_a("t1 after2", 0, 0, 0);

    // Continuous mode; cont drops mid third frame, frame still completes
    cont_a = 1'b1;
    cycle_a("t2 idle", 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      if (i == 9) cont_a = 1'b0;
      cycle_a($sformatf("t2 c%0d", i), i % 4, (i % 4 == 3), 1);
    end
    chk("t2 frames", frames_a, 4);
    cycle_a("t2 after", 0, 0, 0);

    // Stall in IDLE ignored; stall at idx=1 and twice at last tap
    start_a = 1'b1;
    stall_a = 1'b1;
    cycle_a("t3 idle", 0, 0, 0);
    start_a = 1'b0;
    stall_a = 1'b0;
    cycle_a("t3 i0", 0, 0, 1);
    stall_a = 1'b1;
    cycle_a("t3 i1 stall", 1, 0, 1);
    stall_a = 1'b0;
    cycle_a("t3 i1", 1, 0, 1);
    cycle_a("t3 i2", 2, 0, 1);
    stall_a = 1'b1;
    cycle_a("t3 i3 stall0", 3, 0, 1);
    cycle_a("t3 i3 stall1", 3, 0, 1);
    stall_a = 1'b0;
    cycle_a("t3 i3 go", 3, 1, 1);
    chk("t3 frames", frames_a, 5);
    cycle_a("t3 after", 0, 0, 0);

    // Reset at idx=2 overrides a concurrent start
    start_a = 1'b1;
    cycle_a("t4 idle", 0, 0, 0);
    start_a = 1'b0;
    cycle_a("t4 i0", 0, 0, 1);
    cycle_a("t4 i1", 1, 0, 1);
    rst_a   = 1'b1;
    start_a = 1'b1;
    cycle_a("t4 i2 rst", 2, 0, 1);
    rst_a   = 1'b0;
    start_a = 1'b0;
    chk("t4 frames", frames_a, 0);
    cycle_a("t4 post0", 0, 0, 0);
    cycle_a("t4 post1", 0, 0, 0);
    cycle_a("t4 post2", 0, 0, 0);
    chk("t4 frames2", frames_a, 0);

    // NTAPS=5 continuous: 3 frames, wrap 4 -> 0
    cont_b = 1'b1;
    cycle_b("t5 idle", 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cont_b = (i < 12);
      cycle_b($sformatf("t5 c%0d", i), i % 5, (i % 5 == 4), 1);
    end
    chk("t5 frames", frames_b, 3);
    cycle_b("t5 after", 0, 0, 0);

    // FCW=2: five frames chained by start at the last tap
    start_c = 1'b1;
    cycle_c("t6 idle", 0, 0, 0);
    for (int f = 0; f < 5; f++) begin
      for (int t = 0; t < 4; t++) begin
        start_c = (t == 3) && (f < 4);
        chk($sformatf("t6 f%0d t%0d frames", f, t), frames_c, f % 4);
        cycle_c($sformatf("t6 f%0d t%0d", f, t), t, (t == 3), 1);
      end
    end
    start_c = 1'b0;
    chk("t6 frames end", frames_c, 1);
    cycle_c("t6 after", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameters SHALL be:
- NTAPS, default 4: taps per accumulation frame, legal range 2..16.
- SELW, default $clog2(NTAPS): select width.
- FCW, default 8: frame counter width.
REQ-002 Ports SHALL be:
- clk  in  1  single rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request one frame.
- cont  in  1  continuous mode: run frames back-to-back.
- stall  in  1  hold the current tap.
- muxControl  out  SELW  tap select.
- enData  out  1  latch accumulated result.
- clearAccum  out  1  clear accumulator for the next frame.
- busy  out  1  sequencer is in RUN.
- done  out  1  one-cycle frame-complete pulse.
- frames  out  FCW  completed-frame count.
REQ-003 The clock and reset SHALL be exactly one clock, clk, and a synchronous, active-high reset named reset; the block SHALL have no asynchronous state.

Function
REQ-004 The FSM SHALL have two states, IDLE and RUN, plus a SELW-bit tap index idx.
REQ-005 In IDLE, all outputs except frames SHALL be 0:
- muxControl=0, enData=0, clearAccum=0, busy=0, done=0.
REQ-006 IDLE -> RUN SHALL occur on the edge where (start | cont)=1; idx SHALL load 0.
REQ-007 In RUN:
- busy SHALL be 1.
- muxControl SHALL equal idx, combinationally from registered state.
REQ-008 In RUN with stall=1:
- idx and state SHALL hold.
- enData, clearAccum and done SHALL be 0 regardless of idx.
REQ-009 In RUN with stall=0 and idx<NTAPS-1, idx SHALL increment by 1 on the next edge.
REQ-010 Last tap: in RUN with stall=0 and idx=NTAPS-1, the following SHALL be asserted for exactly that cycle:
- enData=1, clearAccum=1, done=1.
REQ-011 After the last-tap cycle of REQ-010:
- frames SHALL increment on the next edge, wrapping from 2^FCW-1 to 0.
- If (start | cont)=1 in that cycle, the FSM SHALL stay in RUN with idx=0 (no bubble).
- Otherwise the FSM SHALL go to IDLE.
REQ-012 start asserted in RUN at any cycle other than the REQ-010 last-tap cycle SHALL be ignored (not queued).
REQ-013 Deasserting cont mid-frame SHALL NOT truncate the frame; the decision is sampled only at the last tap.
REQ-014 With NTAPS=4 and cont=1, the steady-state output pattern per frame SHALL be:
- muxControl 0,1,2,3.
- enData/clearAccum 0,0,0,1.
REQ-015 muxControl SHALL never exceed NTAPS-1; for non-power-of-two NTAPS, idx SHALL wrap from NTAPS-1 to 0, never to 2^SELW.
REQ-016 stall=1 in IDLE SHALL have no effect; start in IDLE SHALL still be accepted.

Reset
REQ-017 On any edge with reset=1, the block SHALL set state=IDLE, idx=0 and frames=0, overriding start, cont and stall.
REQ-018 Reset asserted mid-frame SHALL abort the frame with no done, enData or clearAccum pulse on the reset edge or afterwards.
REQ-019 After reset deasserts, the first RUN cycle SHALL occur no earlier than one edge after (start | cont)=1 is sampled.

Verification
REQ-020 Single frame:
- Stimulus: NTAPS=4, pulse start for 1 cycle.
- Response: muxControl 0,1,2,3; done/enData/clearAccum high only on tap 3; busy high 4 cycles; frames=1; back to IDLE.
REQ-021 Continuous mode:
- Stimulus: NTAPS=4, cont=1 for 12 cycles.
- Response: 3 gapless frames; done on cycles 4, 8 and 12 after RUN entry; frames=3.
REQ-022 Stall on last tap:
- Stimulus: NTAPS=4, stall=1 for 2 cycles while idx=3.
- Response: muxControl=3 for 3 cycles; enData pulses once, only on the unstalled cycle.
REQ-023 Non-power-of-two depth:
- Stimulus: NTAPS=5, cont=1.
- Response: muxControl sequence 0,1,2,3,4,0; value 5, 6 or 7 never appears.
REQ-024 Reset mid-operation:
- Stimulus: reset at idx=2.
- Response: next cycle IDLE, muxControl=0, frames=0; no done pulse.
REQ-025 Counter wrap and start at last tap:
- Stimulus: FCW=2, run 5 single frames, with start held at the last tap of each.
- Response: frames sequence 1,2,3,0,1; frames run back-to-back with no IDLE cycle between them.
